axis_detector_packer: RTL and testbench
=======================================

# axis_detector_packer

Buffers the 128-bit coincidence events from the detector reader and packs them into a 64-bit AXI4-Stream with backpressure, framing them into packets for the DMA writer. The reader's output has no `tready`, so this block absorbs bursts in a small FIFO, counts the events it has to drop, and inserts `tlast` every `cfg` events. It sits between the detector reader and the stream-to-memory DMA.

## Interface
- `FIFO_ADDR_WIDTH`, default 4: FIFO depth is 2^FIFO_ADDR_WIDTH events (16).
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, synchronous, active-low.
- `cfg`  in  16  events per packet; 0 is treated as 1.
- `s_axis_tdata`  in  128  event `{time[61:0], hits[65:0]}`.
- `s_axis_tvalid`  in  1  event strobe; there is no `s_axis_tready`.
- `m_axis_tdata`  out  64  output beat.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last beat of a packet.
- `sts_drops`  out  32  count of dropped events; saturating.
- `sts_level`  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy, in events.

## Operation
- **FIFO**
  - Register array of 2^FIFO_ADDR_WIDTH × 128 bits.
  - Write and read pointers, plus a registered `count`.
  - Head is read combinationally (first-word fall-through).
- **Write**
  - When `s_axis_tvalid` and `count < DEPTH` (registered value), store the word and advance the write pointer.
  - When `s_axis_tvalid` and `count == DEPTH`, drop the event and increment `sts_drops`. It stops at 0xFFFFFFFF and never wraps.
  - A full FIFO rejects the write even if a pop happens in the same cycle.
- **Serialiser**
  - The `phase` register selects the beat: phase 0 outputs `head[63:0]`, phase 1 outputs `head[127:64]`.
  - `m_axis_tvalid = (count != 0)`.
  - On a transfer (`tvalid & tready`):
    - phase 0 → 1.
    - phase 1 → 0: pop the head and advance the packet counter.
  - Each event produces exactly two beats, low half first.
- **Framing**
  - `pkt_cntr` (16 bits) counts events already emitted in the current packet.
  - `m_axis_tlast = phase & (pkt_cntr + 1 >= max(cfg,1))`.
  - On a transfer with `tlast`, `pkt_cntr` goes to 0; otherwise it increments on each pop.
  - Lowering `cfg` mid-packet ends the packet at the next event's second beat. Raising it extends the current packet.
- **Simultaneous push and pop**
  - `count` is unchanged; both pointers advance.
- **Pointer wrap**
  - Pointers wrap modulo the depth; `count` alone distinguishes full from empty.
- **Status**
  - `sts_level` equals `count`.
  - `sts_drops` is cleared only by reset.

## Timing
- **Reset** (`aresetn` low at a rising edge), all clear to 0:
  - FIFO empty; pointers, `phase`, `pkt_cntr` and `sts_drops` cleared.
  - Outputs: `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `sts_level = 0`, `m_axis_tdata = 0`.
  - Reset in mid-packet discards buffered events with no trailing `tlast`. The first beat after reset starts a new packet.
- **Latency**
  - An event sampled at edge N is presented as beat 0 after edge N, provided the FIFO was empty and `phase = 0`.
  - Beat 1 follows one cycle after beat 0 is accepted.
- **Throughput**
  - One beat per cycle with `tready` held high, i.e. one event per 2 cycles.
  - Input bursts faster than that are absorbed up to the FIFO depth.
- **Stability**
  - While `tvalid & ~tready`, `m_axis_tdata` and `m_axis_tlast` hold their values.
  - `tvalid` never deasserts without a transfer (the head is only removed by a pop).
- **Status timing**
  - `sts_drops` updates one cycle after the dropped strobe.
  - `sts_level` updates on the edge after a push or pop.

## Test plan
- **Single event**
  - Stimulus: `cfg = 1`, `tready = 1`, one event `{62'h5, 66'h3}`.
  - Required: beat0 = 64'h3, beat1 = 64'h14, beat1 has `tlast = 1`, then `tvalid = 0`.
- **Packet framing**
  - Stimulus: `cfg = 3`, 7 events spaced 4 cycles apart, `tready = 1`.
  - Required: `tlast` on beats 6 and 12 only; the 7th event is pending with `pkt_cntr = 1`.
- **Overflow**
  - Stimulus: `tready = 0`, 20 back-to-back events, depth 16.
  - Required: `sts_level = 16`, `sts_drops = 4`.
  - Then `tready = 1`: exactly events 0–15 emerge in order across 32 beats.
- **Backpressure**
  - Stimulus: random `tready` (50%) with continuous input at 1 event per 3 cycles.
  - Required: no drops, data unchanged while stalled, order preserved across pointer wrap.
- **Edge cases**
  - `cfg = 0` behaves as `cfg = 1`.
  - Changing `cfg` 4 → 2 with `pkt_cntr = 2` gives `tlast` on the next event.
  - `aresetn` pulsed mid-packet: all outputs 0 on the next cycle, FIFO empty, `sts_drops = 0`.

Source files
------------

// File: rtl/axis_detector_packer_if.sv
// AXI4-Stream bundle shared by the detector packer and its neighbours.
// The monitor view serves sources that have no backpressure.
interface axis_detector_packer_if #(
    parameter int W = 64
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (
        output tdata, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast,
        output tready
    );

    modport monitor (
        input tdata, tvalid
    );
endinterface

// File: rtl/axis_detector_packer.sv
// Buffers 128-bit detector events and serialises them into a framed
// 64-bit AXI4-Stream, counting events lost to a full FIFO.
module axis_detector_packer #(
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [15:0]              cfg,
    axis_detector_packer_if.monitor  s_axis,
    axis_detector_packer_if.master   m_axis,
    output logic [31:0]              sts_drops,
    output logic [FIFO_ADDR_WIDTH:0] sts_level
);
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

    typedef enum logic {
        BEAT_LO,
        BEAT_HI
    } beat_e;

    beat_e        phase_q;
    beat_e        phase_d;
    logic [127:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  count;
    logic [15:0]  pkt_cntr;
    logic [15:0]  cfg_eff;
    logic [127:0] head;
    logic         full;
    logic         push;
    logic         valid;
    logic         xfer;
    logic         pop;
    logic         last_evt;

    assign full  = (count == FULL_LVL);
    assign push  = s_axis.tvalid & ~full;
    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign xfer  = valid & m_axis.tready;
    assign pop   = xfer & (phase_q == BEAT_HI);

    assign cfg_eff  = (cfg == 16'd0) ? 16'd1 : cfg;
    assign last_evt = ({1'b0, pkt_cntr} + 17'd1) >= {1'b0, cfg_eff};

    // Data is forced to zero when empty so the stale head never leaks out.
    assign m_axis.tvalid = valid;
    assign m_axis.tlast  = (phase_q == BEAT_HI) & last_evt;
    assign m_axis.tdata  = !valid ? 64'd0 :
                           (phase_q == BEAT_HI) ? head[127:64] :
                           head[63:0];

    assign sts_level = count;

    always_comb begin
        phase_d = phase_q;
        if (xfer) begin
            phase_d = (phase_q == BEAT_LO) ? BEAT_HI : BEAT_LO;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_axis.tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            phase_q   <= BEAT_LO;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_cntr  <= '0;
            sts_drops <= '0;
        end else begin
            phase_q <= phase_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pkt_cntr <= last_evt ? 16'd0 : pkt_cntr + 16'd1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_axis.tvalid && full && (sts_drops != '1)) begin
                sts_drops <= sts_drops + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_axis_detector_packer.sv
// Directed bench for axis_detector_packer with a small reference
// queue for the random-backpressure section.
module tb_axis_detector_packer;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] cfg;
    logic [31:0] sts_drops;
    logic [4:0]  sts_level;

    int checks = 0;
    int errors = 0;

    logic [127:0] q[$];
    logic         tb_phase;
    logic         stalled;
    logic [63:0]  held_data;
    logic         held_last;
    logic [63:0]  exp_beat;
    int           n_sent;

    axis_detector_packer_if #(.W(128)) s_if ();
    axis_detector_packer_if #(.W(64))  m_if ();

    axis_detector_packer #(.FIFO_ADDR_WIDTH(4)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cfg       (cfg),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .sts_drops (sts_drops),
        .sts_level (sts_level)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ev(input int k);
        return {64'(64'hB000 + k), 64'(64'hA000 + k)};
    endfunction

    // One event through an idle FIFO with tready held high: 4 cycles.
    task automatic send_one(
        input string        tag,
        input logic [127:0] d,
        input logic         exp_last
    );
        s_if.tdata  = d;
        s_if.tvalid = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        chk({tag, "_b0"}, m_if.tdata, d[63:0]);
        chk({tag, "_b0_last"}, m_if.tlast, 1'b0);
        step();
        chk({tag, "_b1"}, m_if.tdata, d[127:64]);
        chk({tag, "_b1_last"}, m_if.tlast, exp_last);
        step();
        chk({tag, "_idle"}, m_if.tvalid, 1'b0);
        step();
    endtask

    initial begin
        aresetn     = 1'b0;
        cfg         = 16'd1;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        s_if.tready = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        step();
        step();
        chk("rst_valid", m_if.tvalid, 1'b0);
        chk("rst_last", m_if.tlast, 1'b0);
        chk("rst_data", m_if.tdata, 64'd0);
        chk("rst_level", sts_level, 5'd0);
        chk("rst_drops", sts_drops, 32'd0);

        // single event {62'h5, 66'h3}
        aresetn     = 1'b1;
        m_if.tready = 1'b1;
        s_if.tdata  = {62'h5, 66'h3};
        s_if.tvalid = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        chk("single_b0", m_if.tdata, 64'h3);
        chk("single_b0_last", m_if.tlast, 1'b0);
        chk("single_level", sts_level, 5'd1);
        step();
        chk("single_b1", m_if.tdata, 64'h14);
        chk("single_b1_last", m_if.tlast, 1'b1);
        step();
        chk("single_idle", m_if.tvalid, 1'b0);

        // framing with cfg=3: tlast on beats 6 and 12
        cfg = 16'd3;
        for (int e = 0; e < 7; e++) begin
            send_one("frm", ev(e), (e % 3) == 2);
        end
        // pkt_cntr is 1 here; 4 then 2 ends the packet one event later
        cfg = 16'd4;
        send_one("cfg4", ev(7), 1'b0);
        cfg = 16'd2;
        send_one("cfg2", ev(8), 1'b1);

        // overflow: 20 events into 16 slots with tready low
        cfg         = 16'd16;
        m_if.tready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s_if.tdata  = ev(100 + k);
            s_if.tvalid = 1'b1;
            step();
        end
        s_if.tvalid = 1'b0;
        chk("ovf_level", sts_level, 5'd16);
        chk("ovf_drops", sts_drops, 32'd4);
        chk("ovf_head", m_if.tdata, ev(100) & 128'hFFFF_FFFF_FFFF_FFFF);
        step();
        step();
        chk("ovf_hold", m_if.tdata, ev(100) & 128'hFFFF_FFFF_FFFF_FFFF);
        chk("ovf_hold_valid", m_if.tvalid, 1'b1);
        m_if.tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_beat = ev(100 + k) & 128'hFFFF_FFFF_FFFF_FFFF;
            chk("ovf_lo", m_if.tdata, exp_beat);
            step();
            exp_beat = ev(100 + k) >> 64;
            chk("ovf_hi", m_if.tdata, exp_beat);
            step();
        end
        chk("ovf_empty", m_if.tvalid, 1'b0);
        chk("ovf_level0", sts_level, 5'd0);

        // random backpressure, one event per 3 cycles, wraps the pointers
        cfg      = 16'd5;
        tb_phase = 1'b0;
        stalled  = 1'b0;
        n_sent   = 0;
        for (int i = 0; i < 600; i++) begin
            if (i >= 90 && q.size() == 0) break;
            s_if.tvalid = (i < 90) && (i % 3 == 0);
            if (s_if.tvalid) begin
                s_if.tdata = ev(200 + n_sent);
                q.push_back(ev(200 + n_sent));
                n_sent++;
            end
            m_if.tready = 1'($urandom_range(0, 1));
            if (stalled) begin
                chk("bp_hold", m_if.tdata, held_data);
                chk("bp_hold_last", m_if.tlast, held_last);
            end
            if (q.size() == 0) begin
                chk("bp_spurious", m_if.tvalid, 1'b0);
                stalled = 1'b0;
            end else if (m_if.tvalid && m_if.tready) begin
                exp_beat = tb_phase ? q[0][127:64] : q[0][63:0];
                chk("bp_beat", m_if.tdata, exp_beat);
                if (tb_phase) void'(q.pop_front());
                tb_phase = ~tb_phase;
                stalled  = 1'b0;
            end else if (m_if.tvalid) begin
                stalled   = 1'b1;
                held_data = m_if.tdata;
                held_last = m_if.tlast;
            end else begin
                stalled = 1'b0;
            end
            step();
        end
        s_if.tvalid = 1'b0;
        chk("bp_drained", q.size(), 0);
        chk("bp_sent", n_sent, 30);
        chk("bp_drops", sts_drops, 32'd4);
        chk("bp_level", sts_level, 5'd0);

        // cfg=0 acts as 1 event per packet
        m_if.tready = 1'b1;
        cfg = 16'd0;
        send_one("cfg0a", ev(300), 1'b1);
        send_one("cfg0b", ev(301), 1'b1);

        // reset in mid-packet
        cfg = 16'd4;
        send_one("pre_rst", ev(310), 1'b0);
        m_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_if.tdata  = ev(311 + k);
            s_if.tvalid = 1'b1;
            step();
        end
        chk("pre_rst_level", sts_level, 5'd3);
        s_if.tdata = ev(314);
        aresetn    = 1'b0;
        step();
        aresetn     = 1'b1;
        s_if.tvalid = 1'b0;
        chk("rst2_valid", m_if.tvalid, 1'b0);
        chk("rst2_last", m_if.tlast, 1'b0);
        chk("rst2_data", m_if.tdata, 64'd0);
        chk("rst2_level", sts_level, 5'd0);
        chk("rst2_drops", sts_drops, 32'd0);
        m_if.tready = 1'b1;
        cfg = 16'd2;
        send_one("post_rst", ev(320), 1'b0);
        send_one("post_rst2", ev(321), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
